pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered program-counter sequencer; replaces the fixed PC+4 adder in the MIPS datapath.
//  Holds PC and computes the next PC from: sequential step, branch, jump, jump-register, exception.
//  Adds a stall hold and a small circular return-address stack (RAS) for call/return tracking.
//  Sits between the control unit and the instruction memory address port.
// PARAMETERS
//  ADDR_W     32            PC width; must be >= 28
//  STEP       4             sequential increment in bytes
//  RESET_VEC  32'h0000_0000 PC value loaded by reset
//  EXC_VEC    32'h8000_0180 PC value loaded on exception
//  RAS_DEPTH  4             return-address stack entries; power of two, >= 2
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high
//  stall         in   1       hold PC and RAS this cycle
//  exc           in   1       redirect to EXC_VEC
//  branch_taken  in   1       take PC-relative branch
//  branch_off    in   16      signed word offset
//  jump          in   1       pseudo-direct jump
//  jump_idx      in   26      jump word index
//  jr            in   1       jump to register target
//  jr_target     in   ADDR_W  register target
//  call          in   1       push PC+STEP onto RAS (qualifies jump or jr)
//  ret           in   1       pop RAS (qualifies jr)
//  pc            out  ADDR_W  current PC
//  pc_plus_step  out  ADDR_W  pc+STEP, combinational, for link register write
//  ras_top       out  ADDR_W  top RAS entry; 0 when empty
//  ras_valid     out  1       RAS non-empty
//  ras_overflow  out  1       sticky: a push hit a full RAS
// BEHAVIOUR
//  - Reset (sync, active-high): pc<=RESET_VEC, RAS count<=0, pointer<=0, ras_overflow<=0.
//    Reset overrides every other input in the same cycle.
//  - Next-PC priority: reset > exc > stall > jr > jump > branch_taken > sequential.
//  - Sequential: pc<=pc+STEP, modulo 2^ADDR_W (wraps, no flag).
//  - Branch: pc<=pc+STEP+(sext(branch_off)<<2), modulo 2^ADDR_W.
//  - Jump: pc<={pc_plus_step[ADDR_W-1:28], jump_idx, 2'b00}.
//  - jr: pc<=jr_target unmodified; misalignment is not checked.
//  - Latency: a redirect applied at edge N appears on pc after edge N; no bubbles.
//  - exc: pc<=EXC_VEC even when stall=1; RAS is unchanged.
//  - stall (no exc): pc, RAS and ras_overflow all hold; call/ret ignored.
//  - RAS actions occur only on an unstalled, non-exception cycle:
//    push when call&(jump|jr); pop when ret&jr; call/ret with no qualifying jump are ignored.
//  - Push when full: overwrite the oldest entry (circular), count stays RAS_DEPTH,
//    and ras_overflow<=1. ras_overflow clears only on reset.
//  - Pop when empty: no state change, no error.
//  - Push and pop in the same cycle: the top entry is replaced by PC+STEP; count unchanged
//    (an empty RAS gets a plain push).
//  - ras_top and ras_valid are combinational from the registered RAS state.
// STRUCTURE
//  - Shared package pc_seq_pkg: next-PC select enum (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC)
//    and default vector constants.
//  - One sub-module, ras_stack: circular buffer with push/pop/replace, full/empty, overflow.
//  - Top level holds the PC register, the target adders, and the priority mux.
// TESTING
//  1. reset=1 for 2 cycles, then release -> pc=0; pc after the next 3 edges = 4, 8, 0xC.
//  2. pc=0x100, branch_taken, off=-2 -> pc=0xFC; off=0x7FFF -> pc=0x100+4+0x1FFFC.
//  3. pc=0x0040_0010, jump, idx=0x0100000 -> pc=0x0040_0000;
//     jr target=0xDEAD_BEE0 -> pc=0xDEAD_BEE0.
//  4. stall=1 for 3 cycles while branch_taken and call are asserted -> pc and RAS are unchanged.
//     exc during stall -> pc=0x8000_0180.
//  5. 5 calls (jump+call) from pc=0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_overflow=1.
//     4 pops (jr+ret) -> ras_top reads 0x54, 0x44, 0x34, 0x24, then ras_valid=0.
//     A 5th pop is ignored.
//  6. Mid-run reset while the RAS holds 2 entries -> ras_valid=0, pc=RESET_VEC on the next edge.
//     Also cover pc=0xFFFF_FFFC sequential -> pc=0 (wrap).

Source files
------------

// File: rtl/pc_seq_pkg.sv
// ============================================================================
//  Module  : pc_seq_pkg
//  Brief   : Shared next-PC select encoding and default vectors.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ = 3'd0,
      SEL_BR  = 3'd1,
      SEL_J   = 3'd2,
      SEL_JR  = 3'd3,
      SEL_EXC = 3'd4
   } pc_sel_e;

   localparam logic [31:0] c_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] c_EXC_VEC   = 32'h8000_0180;
   localparam int          c_STEP      = 4;

endpackage : pc_seq_pkg

`default_nettype wire

// File: rtl/pc_sequencer_ras.sv
// ============================================================================
//  Module  : ras_stack
//  Brief   : Circular return-address stack with push/pop/replace and sticky overflow.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] data_i,
   output logic [ADDR_W-1:0] top_o,
   output logic              valid_o,
   output logic              overflow_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0]  mem_q [DEPTH];
   logic [c_PTR_W-1:0] ptr_q, ptr_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [c_PTR_W-1:0] top_idx;
   logic [c_PTR_W-1:0] wr_idx;
   logic               wr_en;
   logic               empty;
   logic               full;

   // ptr_q is the next free slot; when full it also addresses the oldest entry
   assign top_idx = ptr_q - 1'b1;
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == c_CNT_W'(DEPTH));

   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      wr_en  = 1'b0;
      wr_idx = ptr_q;
      if (push_i && pop_i && !empty) begin
         wr_en  = 1'b1;
         wr_idx = top_idx;
      end else if (push_i) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + 1'b1;
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop_i && !empty) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= data_i;
      end
   end

   assign top_o      = empty ? '0 : mem_q[top_idx];
   assign valid_o    = !empty;
   assign overflow_o = ovf_q;

endmodule : ras_stack

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module  : pc_sequencer
//  Brief   : Registered PC with branch/jump/jr/exception redirect, stall and RAS.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              STEP      = c_STEP,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(c_RESET_VEC),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(c_EXC_VEC),
   parameter int              RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              exc,
   input  logic              branch_taken,
   input  logic [15:0]       branch_off,
   input  logic              jump,
   input  logic [25:0]       jump_idx,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus_step,
   output logic [ADDR_W-1:0] ras_top,
   output logic              ras_valid,
   output logic              ras_overflow
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] br_tgt;
   logic [ADDR_W-1:0] jmp_tgt;
   pc_sel_e           sel;
   logic              hold;
   logic              ras_act;
   logic              ras_push;
   logic              ras_pop;

   assign pc_plus_step = pc_q + ADDR_W'(STEP);
   assign br_tgt       = pc_plus_step + {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};

   generate
      if (ADDR_W > 28) begin : g_jmp_hi
         assign jmp_tgt = {pc_plus_step[ADDR_W-1:28], jump_idx, 2'b00};
      end else begin : g_jmp_lo
         assign jmp_tgt = {jump_idx, 2'b00};
      end
   endgenerate

   always_comb begin
      sel  = SEL_SEQ;
      hold = 1'b0;
      if (exc) begin
         sel = SEL_EXC;
      end else if (stall) begin
         hold = 1'b1;
      end else if (jr) begin
         sel = SEL_JR;
      end else if (jump) begin
         sel = SEL_J;
      end else if (branch_taken) begin
         sel = SEL_BR;
      end
   end

   always_comb begin
      pc_d = pc_plus_step;
      case (sel)
         SEL_EXC: pc_d = EXC_VEC;
         SEL_JR:  pc_d = jr_target;
         SEL_J:   pc_d = jmp_tgt;
         SEL_BR:  pc_d = br_tgt;
         default: pc_d = pc_plus_step;
      endcase
      if (hold) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_VEC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // RAS moves only on a cycle that actually commits a control transfer
   assign ras_act  = !reset && !exc && !stall;
   assign ras_push = ras_act && call && (jump || jr);
   assign ras_pop  = ras_act && ret && jr;

   ras_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk        (clk),
      .reset      (reset),
      .push_i     (ras_push),
      .pop_i      (ras_pop),
      .data_i     (pc_plus_step),
      .top_o      (ras_top),
      .valid_o    (ras_valid),
      .overflow_o (ras_overflow)
   );

   assign pc = pc_q;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module  : tb_pc_sequencer
//  Brief   : Directed scoreboard bench for pc_sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, exc, branch_taken, jump, jr, call, ret;
   logic [15:0] branch_off;
   logic [25:0] jump_idx;
   logic [31:0] jr_target;
   logic [31:0] pc, pc_plus_step, ras_top;
   logic        ras_valid, ras_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic [31:0] top;
      logic        v;
      logic        o;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .exc          (exc),
      .branch_taken (branch_taken),
      .branch_off   (branch_off),
      .jump         (jump),
      .jump_idx     (jump_idx),
      .jr           (jr),
      .jr_target    (jr_target),
      .call         (call),
      .ret          (ret),
      .pc           (pc),
      .pc_plus_step (pc_plus_step),
      .ras_top      (ras_top),
      .ras_valid    (ras_valid),
      .ras_overflow (ras_overflow)
   );

   task automatic chk(input string nm, input string f, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s: got %h expected %h", nm, f, act, req);
      end
   endtask

   // Monitor: every edge that has a pending expectation is checked 1ns later
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "pc",       pc,                  e.pc);
            chk(e.nm, "pc_plus",  pc_plus_step,        e.pc + 32'd4);
            chk(e.nm, "ras_top",  ras_top,             e.top);
            chk(e.nm, "ras_valid",{31'd0, ras_valid},  {31'd0, e.v});
            chk(e.nm, "ras_ovf",  {31'd0, ras_overflow}, {31'd0, e.o});
         end
      end
   end

   // Apply one cycle of inputs and queue the state expected after the next edge
   task automatic step(input string nm, input logic rs, input logic st, input logic ex,
                       input logic br, input logic [15:0] off, input logic j,
                       input logic [25:0] idx, input logic r, input logic [31:0] tgt,
                       input logic cl, input logic rt,
                       input logic [31:0] e_pc, input logic [31:0] e_top,
                       input logic e_v, input logic e_o);
      exp_t e;
      reset = rs; stall = st; exc = ex; branch_taken = br; branch_off = off;
      jump = j; jump_idx = idx; jr = r; jr_target = tgt; call = cl; ret = rt;
      e.nm = nm; e.pc = e_pc; e.top = e_top; e.v = e_v; e.o = e_o;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      //    name       rs st ex br off       j  idx         jr tgt            cl rt  e_pc          e_top         v  o
      step("rst0",     1, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0);
      step("rst1",     1, 0, 0, 1, 16'h0,    1, 26'h5,      1, 32'h1234,      1, 0, 32'h0,        32'h0,        0, 0);
      step("seq1",     0, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'h4,        32'h0,        0, 0);
      step("seq2",     0, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'h8,        32'h0,        0, 0);
      step("seq3",     0, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'hC,        32'h0,        0, 0);
      step("jr100",    0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h100,       0, 0, 32'h100,      32'h0,        0, 0);
      step("br_neg",   0, 0, 0, 1, 16'hFFFE, 0, 26'h0,      0, 32'h0,         0, 0, 32'hFC,       32'h0,        0, 0);
      step("jr100b",   0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h100,       0, 0, 32'h100,      32'h0,        0, 0);
      step("br_max",   0, 0, 0, 1, 16'h7FFF, 0, 26'h0,      0, 32'h0,         0, 0, 32'h20100,    32'h0,        0, 0);
      step("jr_4010",  0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h0040_0010, 0, 0, 32'h0040_0010,32'h0,        0, 0);
      step("jump",     0, 0, 0, 1, 16'h10,   1, 26'h0100000,0, 32'h0,         0, 0, 32'h0040_0000,32'h0,        0, 0);
      step("jr_dead",  0, 0, 0, 0, 16'h0,    1, 26'h3,      1, 32'hDEAD_BEE0, 0, 0, 32'hDEAD_BEE0,32'h0,        0, 0);
      step("jr_call",  0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h200,       1, 0, 32'h200,      32'hDEAD_BEE4,1, 0);
      for (int i = 0; i < 3; i++)
         step("stall", 0, 1, 0, 1, 16'h4,    1, 26'h80,     0, 32'h0,         1, 0, 32'h200,      32'hDEAD_BEE4,1, 0);
      step("exc_stl",  0, 1, 1, 0, 16'h0,    1, 26'h80,     0, 32'h0,         1, 0, 32'h8000_0180,32'hDEAD_BEE4,1, 0);
      step("rst_mid0", 1, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0);
      step("jr10",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h10,        0, 0, 32'h10,       32'h0,        0, 0);
      step("call1",    0, 0, 0, 0, 16'h0,    1, 26'h8,      0, 32'h0,         1, 0, 32'h20,       32'h14,       1, 0);
      step("call2",    0, 0, 0, 0, 16'h0,    1, 26'hC,      0, 32'h0,         1, 0, 32'h30,       32'h24,       1, 0);
      step("call3",    0, 0, 0, 0, 16'h0,    1, 26'h10,     0, 32'h0,         1, 0, 32'h40,       32'h34,       1, 0);
      step("call4",    0, 0, 0, 0, 16'h0,    1, 26'h14,     0, 32'h0,         1, 0, 32'h50,       32'h44,       1, 0);
      step("call5",    0, 0, 0, 0, 16'h0,    1, 26'h100,    0, 32'h0,         1, 0, 32'h400,      32'h54,       1, 1);
      step("call_nq",  0, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         1, 1, 32'h404,      32'h54,       1, 1);
      step("pop1",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h54,        0, 1, 32'h54,       32'h44,       1, 1);
      step("pop2",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h44,        0, 1, 32'h44,       32'h34,       1, 1);
      step("pop3",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h34,        0, 1, 32'h34,       32'h24,       1, 1);
      step("pop4",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h24,        0, 1, 32'h24,       32'h0,        0, 1);
      step("pop5",     0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h600,       0, 1, 32'h600,      32'h0,        0, 1);
      step("push_a",   0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h700,       1, 0, 32'h700,      32'h604,      1, 1);
      step("replace",  0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h800,       1, 1, 32'h800,      32'h704,      1, 1);
      step("push_b",   0, 0, 0, 0, 16'h0,    1, 26'h240,    0, 32'h0,         1, 0, 32'h900,      32'h804,      1, 1);
      step("pop_b",    0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'h804,       0, 1, 32'h804,      32'h704,      1, 1);
      step("push_c",   0, 0, 0, 0, 16'h0,    1, 26'h280,    0, 32'h0,         1, 0, 32'hA00,      32'h808,      1, 1);
      step("rst_mid",  1, 0, 0, 0, 16'h0,    1, 26'h5,      0, 32'h0,         1, 0, 32'h0,        32'h0,        0, 0);
      step("jr_top",   0, 0, 0, 0, 16'h0,    0, 26'h0,      1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC,32'h0,        0, 0);
      step("wrap",     0, 0, 0, 0, 16'h0,    0, 26'h0,      0, 32'h0,         0, 0, 32'h0,        32'h0,        0, 0);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pc_sequencer

`default_nettype wire
